// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage pipeline.
//
// Owns the PC and issues one request at a time to a variable-latency
// instruction memory. The result goes into the IF/ID register that decode
// consumes. Stall freezes the PC and IF/ID. Br_Taken redirects the PC and
// flushes IF/ID. Br_Taken has priority over Stall.
//
// Parameters
//   ADDR_W    PC / instruction address width
//   DATA_W    instruction width
//   RESET_PC  PC value after reset
//
// Ports
//   clk, rst            clock (rising edge); asynchronous active-low reset
//   Stall               hazard-unit freeze of PC and IF/ID
//   Br_Taken, Br_Addr   redirect from EXE
//   imem_req/addr       request to instruction memory; addr stable until ack
//   imem_ack/rdata      one-cycle response strobe and instruction
//   IF_PC               IF/ID: PC+4 of held instruction
//   IF_Inst             IF/ID: instruction (0 when invalid)
//   IF_Valid            IF/ID holds a real instruction
//   stall_cnt/flush_cnt saturating performance counters; these ports exist
//                       only when FETCH_PERF_CNT_EN is defined

module fetch_stage #(
   parameter int unsigned         ADDR_W   = 32,
   parameter int unsigned         DATA_W   = 32,
   parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Stall,
   input  logic              Br_Taken,
   input  logic [ADDR_W-1:0] Br_Addr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0] IF_PC,
   output logic [DATA_W-1:0] IF_Inst,
   output logic              IF_Valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,   // request outstanding, response is used
      S_HOLD = 2'd1,   // response parked in skid register, no request
      S_DROP = 2'd2    // stale request outstanding, response is discarded
   } state_t;

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   state_t              state_q,    state_d;
   logic [ADDR_W-1:0]   pc_q,       pc_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic [DATA_W-1:0]   skid_q,     skid_d;
   logic [ADDR_W-1:0]   if_pc_q,    if_pc_d;
   logic [DATA_W-1:0]   if_inst_q,  if_inst_d;
   logic                if_valid_q, if_valid_d;
   logic [ADDR_W-1:0]   pc_inc;

   assign pc_inc = pc_q + PC_STEP;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      skid_d     = skid_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      if_valid_d = if_valid_q;

      unique case (state_q)
         S_REQ: begin
            if (Br_Taken) begin
               pc_d       = Br_Addr;
               if_pc_d    = '0;
               if_inst_d  = '0;
               if_valid_d = 1'b0;
               // A response arriving together with the branch is simply
               // dropped. Without one, the in-flight request must drain first.
               state_d    = imem_ack ? S_REQ : S_DROP;
            end else if (imem_ack) begin
               if (!Stall) begin
                  if_pc_d    = pc_inc;
                  if_inst_d  = imem_rdata;
                  if_valid_d = 1'b1;
                  pc_d       = pc_inc;
               end else begin
                  skid_d  = imem_rdata;
                  state_d = S_HOLD;
               end
            end else if (!Stall) begin
               if_valid_d = 1'b0;
               if_inst_d  = '0;
            end
         end

         S_HOLD: begin
            if (Br_Taken) begin
               pc_d       = Br_Addr;
               if_pc_d    = '0;
               if_inst_d  = '0;
               if_valid_d = 1'b0;
               state_d    = S_REQ;
            end else if (!Stall) begin
               if_pc_d    = pc_inc;
               if_inst_d  = skid_q;
               if_valid_d = 1'b1;
               pc_d       = pc_inc;
               state_d    = S_REQ;
            end
         end

         S_DROP: begin
            if_pc_d    = '0;
            if_inst_d  = '0;
            if_valid_d = 1'b0;
            if (Br_Taken) pc_d = Br_Addr;
            if (imem_ack) state_d = S_REQ;
         end

         default: state_d = S_REQ;
      endcase

      // A new request starts on entry to REQ, or in REQ right after an ack.
      // Its address is the PC that this cycle produces.
      if (state_d == S_REQ && (state_q != S_REQ || imem_ack))
         req_addr_d = pc_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         skid_q     <= '0;
         if_pc_q    <= '0;
         if_inst_q  <= '0;
         if_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         skid_q     <= skid_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
         if_valid_q <= if_valid_d;
      end
   end

   assign imem_req  = rst && (state_q != S_HOLD);
   assign imem_addr = req_addr_q;
   assign IF_PC     = if_pc_q;
   assign IF_Inst   = if_inst_q;
   assign IF_Valid  = if_valid_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (Stall && !Br_Taken && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
      if (Br_Taken && flush_cnt_q != '1)           flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// The memory model returns rdata = address. Its latency is the number of
// wait cycles before the ack cycle: 0 means the ack comes in the same cycle
// as the request. An expected-instruction queue is filled as each phase is
// set up. It is drained when IF/ID presents a new instruction.
// When FETCH_PERF_CNT_EN is defined, the counter ports are also checked.

module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        Stall;
   logic        Br_Taken;
   logic [31:0] Br_Addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] IF_PC;
   logic [31:0] IF_Inst;
   logic        IF_Valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
      .clk        (clk),
      .rst        (rst),
      .Stall      (Stall),
      .Br_Taken   (Br_Taken),
      .Br_Addr    (Br_Addr),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .IF_PC      (IF_PC),
      .IF_Inst    (IF_Inst),
      .IF_Valid   (IF_Valid)
`ifdef FETCH_PERF_CNT_EN
      ,
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Memory model
   int unsigned lat = 0;
   int unsigned wait_cnt;

   assign imem_ack   = rst && imem_req && (wait_cnt == lat);
   assign imem_rdata = imem_addr;

   always @(posedge clk or negedge rst) begin
      if (!rst)          wait_cnt <= 0;
      else if (imem_req) wait_cnt <= imem_ack ? 0 : wait_cnt + 1;
   end

   // Checking
   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t sb_q[$];

   task automatic push(input logic [31:0] inst);
      exp_t e;
      e.inst = inst;
      e.pc   = inst + 32'd4;
      sb_q.push_back(e);
   endtask

   // A new instruction is one that is valid and was not being held from the
   // previous cycle.
   logic        prev_valid = 1'b0;
   logic [31:0] prev_pc    = '0;

   always @(negedge clk) begin
      exp_t e;
      if (rst && IF_Valid && (!prev_valid || IF_PC != prev_pc)) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_inst", 64'(sb_q.size()), 64'd1);
         end else begin
            e = sb_q.pop_front();
            chk("sb_pc", IF_PC, e.pc);
            chk("sb_inst", IF_Inst, e.inst);
         end
      end
      prev_valid = rst && IF_Valid;
      prev_pc    = IF_PC;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_if(input string tag, input logic v, input logic [31:0] inst, input logic [31:0] pc);
      chk({tag, "_valid"}, IF_Valid, v);
      chk({tag, "_inst"}, IF_Inst, inst);
      chk({tag, "_pc"}, IF_PC, pc);
   endtask

   task automatic chk_cnt(input logic [31:0] s, input logic [31:0] f);
`ifdef FETCH_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, s);
      chk("flush_cnt", flush_cnt, f);
`else
      if (s != f) begin end
`endif
   endtask

   // Assert reset between edges, while a request is normally in flight.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk_if("async_rst", 1'b0, 32'h0, 32'h0);
      chk("async_rst_req", imem_req, 1'b0);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      chk_cnt(32'd0, 32'd0);
      Stall    = 1'b0;
      Br_Taken = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic release_rst(input int unsigned l);
      lat = l;
      rst = 1'b1;
      #1;
      chk("rel_req", imem_req, 1'b1);
      chk("rel_addr", imem_addr, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within the time bound");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b0;
      Stall    = 1'b0;
      Br_Taken = 1'b0;
      Br_Addr  = '0;
      #1;
      chk_if("reset", 1'b0, 32'h0, 32'h0);
      chk("reset_req", imem_req, 1'b0);
      chk_cnt(32'd0, 32'd0);
      @(posedge clk);
      #1;

      // Zero-wait memory: one instruction per cycle
      for (int unsigned k = 0; k < 4; k++) push(32'(4 * k));
      release_rst(0);
      for (int unsigned k = 1; k <= 4; k++) begin
         step();
         chk_if("zw", 1'b1, 32'(4 * (k - 1)), 32'(4 * k));
         chk("zw_addr", imem_addr, 32'(4 * k));
      end
      chk_cnt(32'd0, 32'd0);
      do_reset();

      // Two wait cycles: one instruction every three cycles
      push(32'h0); push(32'h4); push(32'h8);
      release_rst(2);
      step(); chk("lat_addr1", imem_addr, 32'h0); chk("lat_ack1", imem_ack, 1'b0); chk("lat_v1", IF_Valid, 1'b0);
      step(); chk("lat_addr2", imem_addr, 32'h0); chk("lat_ack2", imem_ack, 1'b1); chk("lat_v2", IF_Valid, 1'b0);
      step(); chk_if("lat_i0", 1'b1, 32'h0, 32'h4); chk("lat_addr3", imem_addr, 32'h4);
      step(); chk("lat_bub1", IF_Valid, 1'b0); chk("lat_bub1_inst", IF_Inst, 32'h0);
      step(); chk("lat_bub2", IF_Valid, 1'b0);
      step(); chk_if("lat_i4", 1'b1, 32'h4, 32'h8);
      step(); chk("lat_bub3", IF_Valid, 1'b0);
      step(); chk("lat_bub4", IF_Valid, 1'b0);
      step(); chk_if("lat_i8", 1'b1, 32'h8, 32'hC);
      do_reset();

      // Stall for 3 cycles while the ack for 0x8 arrives
      push(32'h0); push(32'h4); push(32'h8); push(32'hC);
      release_rst(0);
      step(); chk_if("st_i0", 1'b1, 32'h0, 32'h4);
      step(); chk_if("st_i4", 1'b1, 32'h4, 32'h8); chk("st_ack8", imem_ack, 1'b1);
      Stall = 1'b1;
      for (int unsigned k = 0; k < 3; k++) begin
         step();
         chk_if("st_hold", 1'b1, 32'h4, 32'h8);
         chk("st_hold_req", imem_req, 1'b0);
      end
      Stall = 1'b0;
      step(); chk_if("st_i8", 1'b1, 32'h8, 32'hC); chk("st_next_addr", imem_addr, 32'hC); chk("st_next_req", imem_req, 1'b1);
      step(); chk_if("st_iC", 1'b1, 32'hC, 32'h10);
      chk_cnt(32'd3, 32'd0);
      do_reset();

      // Stall while waiting, then branch during an outstanding 0x10 request
      push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h100);
      release_rst(0);
      step(); step(); step();
      step(); chk_if("br_iC", 1'b1, 32'hC, 32'h10); chk("br_addr10", imem_addr, 32'h10);
      lat   = 3;
      Stall = 1'b1;
      step(); chk_if("br_stall_noack", 1'b1, 32'hC, 32'h10); chk("br_noack", imem_ack, 1'b0);
      Stall    = 1'b0;
      Br_Taken = 1'b1;
      Br_Addr  = 32'h100;
      step(); chk_if("br_flush", 1'b0, 32'h0, 32'h0); chk("br_drop_req", imem_req, 1'b1); chk("br_drop_addr", imem_addr, 32'h10);
      Br_Taken = 1'b0;
      step(); chk("br_drop_ack", imem_ack, 1'b1); chk("br_drop_v", IF_Valid, 1'b0); chk("br_drop_addr2", imem_addr, 32'h10);
      step(); chk("br_tgt_addr", imem_addr, 32'h100); chk("br_tgt_v", IF_Valid, 1'b0);
      lat = 0;
      step(); chk_if("br_i100", 1'b1, 32'h100, 32'h104);
      chk_cnt(32'd1, 32'd1);
      do_reset();

      // Branch and Stall together in HOLD: flush wins, skid discarded
      push(32'h0); push(32'h40);
      release_rst(0);
      step(); chk_if("hb_i0", 1'b1, 32'h0, 32'h4);
      Stall = 1'b1;
      step(); chk_if("hb_hold", 1'b1, 32'h0, 32'h4); chk("hb_hold_req", imem_req, 1'b0);
      Br_Taken = 1'b1;
      Br_Addr  = 32'h40;
      step(); chk_if("hb_flush", 1'b0, 32'h0, 32'h0); chk("hb_req", imem_req, 1'b1); chk("hb_addr", imem_addr, 32'h40);
      Br_Taken = 1'b0;
      Stall    = 1'b0;
      step(); chk_if("hb_i40", 1'b1, 32'h40, 32'h44);
      chk_cnt(32'd1, 32'd1);
      do_reset();

      // Branch with a same-cycle ack (response dropped), target wraps PC
      push(32'h0); push(32'h4); push(32'hFFFF_FFFC); push(32'h0);
      release_rst(0);
      step();
      step(); chk("wr_ack8", imem_ack, 1'b1); chk("wr_addr8", imem_addr, 32'h8);
      Br_Taken = 1'b1;
      Br_Addr  = 32'hFFFF_FFFC;
      step(); chk_if("wr_flush", 1'b0, 32'h0, 32'h0); chk("wr_addr", imem_addr, 32'hFFFF_FFFC); chk("wr_req", imem_req, 1'b1);
      Br_Taken = 1'b0;
      step(); chk_if("wr_top", 1'b1, 32'hFFFF_FFFC, 32'h0);
      step(); chk_if("wr_wrap", 1'b1, 32'h0, 32'h4);
      chk_cnt(32'd0, 32'd1);
      do_reset();

      // Fetch restarts cleanly at RESET_PC after a mid-request reset
      push(32'h0);
      release_rst(0);
      step(); chk_if("rs_i0", 1'b1, 32'h0, 32'h4);
      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
